rx_fifo: RTL
============

# rx_fifo

Receive FIFO sitting directly downstream of the PIO state machine's input shift register (ISR). It accepts 32-bit words when the state machine executes PUSH or autopush. It holds them for the system bus, which reads them in order. Blocking pushes stall the state machine when the FIFO is full; non-blocking pushes to a full FIFO are dropped and flagged.

## Interface
- `DEPTH`, 4: entries per FIFO in unjoined mode; power of two, at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `penable`  in  1  state-machine clock enable; gates the push side only.
- `push`  in  1  push request from the state machine (PUSH or autopush).
- `push_block`  in  1  1 = blocking push (stall if full); 0 = drop if full.
- `push_data`  in  32  ISR contents to enqueue.
- `stall`  out  1  combinational; the push is held and the state machine must not advance.
- `rd_en`  in  1  system-bus pop request.
- `rd_data`  out  32  head entry (first-word fall-through); 0 when empty.
- `join`  in  1  1 = doubled depth (`2*DEPTH`), borrowing TX storage.
- `clear_flags`  in  1  clears sticky flags.
- `empty`, `full`  out  1 each  occupancy status.
- `level`  out  4  current entry count.
- `overflow`  out  1  sticky; a non-blocking push was dropped.
- `underflow`  out  1  sticky; `rd_en` was asserted while empty.

## Operation
- Storage is a circular buffer of `2*DEPTH` words, with read pointer, write pointer and count registers. Capacity is `DEPTH` or `2*DEPTH` according to `join`.
- A push is *effective* when `push && penable`.
- An effective push with not-full, or with full plus `rd_en` in the same cycle, writes `push_data` at the write pointer. The pointer increments and wraps at capacity.
- An effective push with full, no `rd_en` and `push_block=1`:
  - `stall=1`, nothing written.
  - The state machine re-presents the push on later cycles.
- An effective push with full, no `rd_en` and `push_block=0`:
  - The data is discarded and `overflow` is set.
  - `stall=0`.
- `rd_en` with not-empty pops the head. `rd_en` with empty sets `underflow`, changes nothing else, and `rd_data` reads 0.
- Simultaneous push and pop:
  - Non-empty: both occur and `level` is unchanged.
  - Empty: the pop counts as underflow and the push is stored, so `level` becomes 1.
- A change of `join`, detected against a registered copy, flushes the FIFO on that edge: pointers and count go to 0. Any push or pop on that edge is ignored, while the flags keep their state.
- `clear_flags` clears `overflow` and `underflow`. Set takes priority over clear on the same edge.
- `level` = count. `empty` = (count == 0). `full` = (count == capacity).

## Timing
- Reset (async assert, sync-safe deassert) sets:
  - pointers, count and registered `join` to 0.
  - `overflow` and `underflow` to 0.
  - `empty=1`, `full=0`, `level=0`, `rd_data=0`, `stall=0`.
- A word pushed at edge N is visible on `rd_data` after edge N: zero-cycle read latency after the write.
- `stall` is purely combinational from `push`, `penable`, `push_block`, `full` and `rd_en`, with no registered delay. A stalled push completes on the first edge where a slot frees or `rd_en` is high.
- Reset mid-operation discards all contents immediately and asynchronously.
- Status outputs (`empty`, `full`, `level`) are registered-derived and update one edge after the causing event.

## Configuration
- `RX_FIFO_JOIN_EN` defined:
  - storage is `2*DEPTH` words.
  - `join` selects the capacity.
  - `join` changes flush the FIFO.
- Not defined:
  - storage is `DEPTH` words.
  - `join` is ignored (capacity always `DEPTH`) and no flush logic is built.
  - `level` still 4 bits wide.

## Test plan
- Reset, then four pushes of 0x11,0x22,0x33,0x44 -> `full=1`, `level=4`; four pops return 0x11..0x44 in order, then `empty=1`.
- Full FIFO, non-blocking push of 0xDEAD -> `overflow=1`, `stall=0`, `level=4`; contents unchanged; `clear_flags` -> `overflow=0`.
- Full FIFO, blocking push of 0xBEEF held for 3 cycles -> `stall=1` for 3 cycles; `rd_en` on the 4th -> `stall=0`, 0xBEEF stored, `level=4`.
- Empty FIFO, `rd_en` together with a push of 0x5 -> `underflow=1`, `level=1`, `rd_data=0x5`.
- With `RX_FIFO_JOIN_EN`, `join=1`: eight pushes accepted and the 9th non-blocking push sets `overflow`; toggle `join` -> `level=0`, `empty=1`.
- Three words queued, `reset_n` pulsed low mid-cycle -> outputs at reset values immediately; `rd_data=0`.

Source files
------------

// File: rtl/rx_fifo.sv
// Receive FIFO between the state-machine ISR and the system bus.
// Define RX_FIFO_JOIN_EN to build doubled storage and the join flush.
module rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        penable,
    input  logic        push,
    input  logic        push_block,
    input  logic [31:0] push_data,
    output logic        stall,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    input  logic        fifo_join,
    input  logic        clear_flags,
    output logic        empty,
    output logic        full,
    output logic [3:0]  level,
    output logic        overflow,
    output logic        underflow
);

`ifdef RX_FIFO_JOIN_EN
    localparam int NSTORE = 2 * DEPTH;
`else
    localparam int NSTORE = DEPTH;
`endif
    localparam int PW = (NSTORE > 1) ? $clog2(NSTORE) : 1;
    localparam int CW = $clog2(2 * DEPTH) + 1;

    logic [31:0]   r_mem [NSTORE];
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_udf;

    logic [CW-1:0] w_cap;
    logic          w_flush;
    logic          w_empty;
    logic          w_full;
    logic          w_eff;
    logic          w_wr;
    logic          w_rd;
    logic          w_drop;
    logic          w_udf_set;

`ifdef RX_FIFO_JOIN_EN
    logic          r_join;

    // Registered join copy; a mismatch flags a mode change to flush on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_join <= 1'b0;
        else          r_join <= fifo_join;
    end

    assign w_cap   = r_join ? CW'(2 * DEPTH) : CW'(DEPTH);
    assign w_flush = fifo_join ^ r_join;
`else
    logic          w_unused_join;

    assign w_unused_join = fifo_join;
    assign w_cap         = CW'(DEPTH);
    assign w_flush       = 1'b0;
`endif

    function automatic logic [PW-1:0] ptr_nxt(
        input logic [PW-1:0] p,
        input logic [CW-1:0] cap
    );
        if (CW'(p) + CW'(1) == cap) ptr_nxt = '0;
        else                        ptr_nxt = p + PW'(1);
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == w_cap);
    assign w_eff     = push && penable;
    assign w_wr      = w_eff && (!w_full || rd_en);
    assign w_rd      = rd_en && !w_empty;
    assign w_drop    = w_eff && w_full && !rd_en && !push_block;
    assign w_udf_set = rd_en && w_empty;

    assign stall     = w_eff && w_full && !rd_en && push_block;
    assign empty     = w_empty;
    assign full      = w_full;
    assign level     = 4'(r_count);
    assign overflow  = r_ovf;
    assign underflow = r_udf;
    assign rd_data   = w_empty ? 32'h0 : r_mem[r_rptr];

    // Storage write; contents need no reset since reads gate on empty.
    always_ff @(posedge clk) begin
        if (w_wr && !w_flush) r_mem[r_wptr] <= push_data;
    end

    // Pointers and occupancy count, flushed on a join change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= ptr_nxt(r_wptr, w_cap);
            if (w_rd) r_rptr <= ptr_nxt(r_rptr, w_cap);
            if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
            else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
        end
    end

    // Sticky error flags; a new event wins over clear, flush holds them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (!w_flush) begin
            if (w_drop)           r_ovf <= 1'b1;
            else if (clear_flags) r_ovf <= 1'b0;
            if (w_udf_set)        r_udf <= 1'b1;
            else if (clear_flags) r_udf <= 1'b0;
        end
    end

endmodule
